mem_wait_stage: RTL and testbench
=================================

MEM_WAIT_STAGE -- requirements
Module: mem_wait_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, number of data words stored.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 4, legal range 1..255, stall cycles per access.
REQ-004 The block SHALL have parameter BASE_ADDR, default 1024, byte address of word 0.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port mem_r_en, input, 1, read request from the EXE/MEM register.
REQ-008 The block SHALL have port mem_w_en, input, 1, write request from the EXE/MEM register.
REQ-009 The block SHALL have port address, input, 32, byte address (ALU result).
REQ-010 The block SHALL have port wdata, input, DATA_W, store data (Val_Rm).
REQ-011 The block SHALL have port rdata, output, DATA_W, registered load data.
REQ-012 The block SHALL have port ready, output, 1, 1 = stage may advance; the pipeline freezes on ~ready.
REQ-013 The block SHALL have port addr_err, output, 1, access fault flag, valid only while ready=1 in the DONE state.
REQ-014 The block SHALL have port stall_cnt, output, 16, saturating count of cycles with ready=0.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and DONE, and state SHALL be registered.
REQ-016 In IDLE with no request, ready SHALL be 1 and the state SHALL remain IDLE.
REQ-017 In IDLE with mem_r_en|mem_w_en, ready SHALL drop to 0 combinationally in the same cycle.
REQ-018 From IDLE with a request, the next state SHALL be BUSY if WAIT_CYCLES>1, else DONE.
REQ-019 BUSY SHALL last exactly WAIT_CYCLES-1 cycles, timed by a down-counter loaded on IDLE->BUSY, with ready=0 throughout.
REQ-020 Total ready=0 cycles per access SHALL be exactly WAIT_CYCLES, counting the request cycle.
REQ-021 DONE SHALL last one cycle with ready=1, then return to IDLE; requests seen during DONE SHALL be ignored as the same instruction.
REQ-022 The write to memory and the rdata capture SHALL occur on the edge entering DONE.
REQ-023 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-024 The requester SHALL hold all inputs stable while ready=0; the block SHALL sample them only on the edge entering DONE.
REQ-025 The word index SHALL be (address-BASE_ADDR)>>2.
REQ-026 The access SHALL fault if address<BASE_ADDR, index>=DEPTH, or address[1:0]!=0.
REQ-027 A faulting access SHALL suppress the write, load rdata with 0, and set addr_err=1 in DONE.
REQ-028 mem_r_en and mem_w_en asserted together SHALL be treated as a faulting access with the same response, still taking the full WAIT_CYCLES.
REQ-029 addr_err SHALL be 0 in IDLE and BUSY.
REQ-030 stall_cnt SHALL increment on every cycle with ready=0 and saturate at 16'hFFFF.
REQ-031 Back-to-back accesses SHALL be separated by DONE; the next request is accepted in the following IDLE cycle.

Reset
REQ-032 Reset SHALL force IDLE, counter 0, rdata 0, addr_err 0 and stall_cnt 0 on the next edge.
REQ-033 While reset=1, ready SHALL be 1 regardless of requests.
REQ-034 Reset mid-access SHALL abort the access with no memory write.
REQ-035 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-036 The bench SHALL cover this write-then-read scenario: WAIT_CYCLES=4, write 0xDEADBEEF to 1024, then read 1024 -> ready low 4 cycles each; rdata=0xDEADBEEF in the read's DONE cycle; addr_err=0.
REQ-037 The bench SHALL cover this minimum-wait scenario: WAIT_CYCLES=1, read of 1028 after writing 0x12345678 -> ready low 1 cycle; DONE next cycle; rdata=0x12345678.
REQ-038 The bench SHALL cover these faulting-access cases: read at 1022, 1025 and 1024+4*DEPTH -> addr_err=1 in DONE, rdata=0, memory unchanged.
REQ-039 The bench SHALL cover this simultaneous-request case: mem_r_en=mem_w_en=1 at 1032 -> full stall, addr_err=1, word 2 unchanged.
REQ-040 The bench SHALL cover this reset-abort case: reset asserted in the 2nd BUSY cycle of a write of 0xAAAA5555 -> ready=1 during reset, IDLE after, a later read returns the old value, stall_cnt=0.
REQ-041 The bench SHALL cover this counter-saturation case: stall_cnt preloaded via 65535 stall cycles plus further stalls -> holds 0xFFFF.

Source files
------------

// File: rtl/mem_wait_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_stage
//  Description : Memory pipeline stage that models a fixed-latency data memory.
//                It freezes the pipeline for WAIT_CYCLES per access and flags
//                faulting accesses.
//  Revision    : 1.0  - initial release
// ============================================================================
module mem_wait_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              addr_err,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_DEPTH     = 32'(DEPTH);
    localparam bit          c_SKIP_BUSY = (WAIT_CYCLES <= 1);
    // BUSY spans WAIT_CYCLES-1 cycles; the counter expires when it reads zero.
    localparam logic [7:0]  c_BUSY_LOAD = (WAIT_CYCLES > 1) ? 8'(WAIT_CYCLES - 2) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_busy_cnt;
    logic [7:0]          w_busy_cnt_nxt;
    logic                w_req;
    logic                w_enter_done;
    logic                w_fault;
    logic [29:0]         w_word;
    logic [1:0]          w_unused_lsb;
    logic [c_IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rdata;
    logic                r_addr_err;
    logic [15:0]         r_stall_cnt;

    assign w_req = mem_r_en | mem_w_en;

    // Word offset from the base; the byte lane bits are checked on address itself.
    assign {w_word, w_unused_lsb} = address - BASE_ADDR;
    assign w_idx   = w_word[c_IDX_W-1:0];
    assign w_fault = (address < BASE_ADDR)
                   || ({2'b00, w_word} >= c_DEPTH)
                   || (address[1:0] != 2'b00)
                   || (mem_r_en && mem_w_en);

    always_comb begin
        w_state_nxt    = r_state;
        w_busy_cnt_nxt = r_busy_cnt;
        w_enter_done   = 1'b0;
        ready          = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    ready = 1'b0;
                    if (c_SKIP_BUSY) begin
                        w_state_nxt  = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt    = S_BUSY;
                        w_busy_cnt_nxt = c_BUSY_LOAD;
                    end
                end
            end
            S_BUSY: begin
                ready = 1'b0;
                if (r_busy_cnt == 8'd0) begin
                    w_state_nxt  = S_DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_busy_cnt_nxt = r_busy_cnt - 8'd1;
                end
            end
            S_DONE: begin
                // Requests still held here belong to the instruction just served.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (reset) begin
            ready        = 1'b1;
            w_enter_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy_cnt  <= 8'd0;
            r_rdata     <= '0;
            r_addr_err  <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
            r_addr_err <= w_enter_done && w_fault;
            if (w_enter_done) begin
                if (w_fault) begin
                    r_rdata <= '0;
                end else if (mem_r_en) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
            if (!ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_enter_done && mem_w_en && !w_fault) begin
            r_mem[w_idx] <= wdata;
        end
    end

    assign rdata     = r_rdata;
    assign addr_err  = r_addr_err;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wait_stage
//  Description : Self-checking bench for mem_wait_stage (three configurations).
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_mem_wait_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // Instance A: WAIT_CYCLES=4, instance B: WAIT_CYCLES=1, instance C: WAIT_CYCLES=255
    logic        a_r = 1'b0, a_w = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic        a_ready, a_err;
    logic [15:0] a_stall;
    logic        b_r = 1'b0, b_w = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic        b_ready, b_err;
    logic [15:0] b_stall;
    logic        c_r = 1'b0, c_w = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, c_rdata;
    logic        c_ready, c_err;
    logic [15:0] c_stall;

    mem_wait_stage #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(4), .BASE_ADDR(32'd1024)) u_dut_a (
        .clk(clk), .reset(reset), .mem_r_en(a_r), .mem_w_en(a_w), .address(a_addr),
        .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .addr_err(a_err), .stall_cnt(a_stall)
    );
    mem_wait_stage #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut_b (
        .clk(clk), .reset(reset), .mem_r_en(b_r), .mem_w_en(b_w), .address(b_addr),
        .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .addr_err(b_err), .stall_cnt(b_stall)
    );
    mem_wait_stage #(.DATA_W(32), .DEPTH(4), .WAIT_CYCLES(255), .BASE_ADDR(32'd1024)) u_dut_c (
        .clk(clk), .reset(reset), .mem_r_en(c_r), .mem_w_en(c_w), .address(c_addr),
        .wdata(c_wdata), .rdata(c_rdata), .ready(c_ready), .addr_err(c_err), .stall_cnt(c_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall [2] = '{0, 0};

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            a_r = r; a_w = w; a_addr = addr; a_wdata = data;
        end else begin
            b_r = r; b_w = w; b_addr = addr; b_wdata = data;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction
    function automatic logic er(input int sel);
        return (sel == 0) ? a_err : b_err;
    endfunction
    function automatic logic [31:0] rd(input int sel);
        return (sel == 0) ? a_rdata : b_rdata;
    endfunction
    function automatic logic [15:0] st(input int sel);
        return (sel == 0) ? a_stall : b_stall;
    endfunction

    // One complete access from IDLE; checks stall length and the DONE-cycle outputs.
    task automatic access(input int sel, input int waitc, input logic r, input logic w,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        drive(sel, r, w, addr, data);
        #1;
        n = 0;
        while (!rdy(sel) && n < 1000) begin
            n++;
            check({tag, " err_while_stalled"}, 32'(er(sel)), 32'd0);
            @(negedge clk);
            #1;
        end
        exp_stall[sel] += waitc;
        check({tag, " stall_len"}, 32'(n), 32'(waitc));
        check({tag, " rdata"}, rd(sel), exp_rdata);
        check({tag, " addr_err"}, 32'(er(sel)), 32'(exp_err));
        check({tag, " stall_cnt"}, 32'(st(sel)), 32'(exp_stall[sel]));
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd1022, 32'h00000000, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'd1025, 32'h00000000, 32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'd1280, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'd1032, 32'h11112222, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'd1032, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h11112222, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'd1276, 32'hCAFE0001, 32'h11112222, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'd1276, 32'h00000000, 32'hCAFE0001, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'h0BADF00D, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'd1280, 32'h55555555, 32'h00000000, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'd1276, 32'h00000000, 32'hCAFE0001, 1'b0};

        // Reset with a pending request: ready must stay high.
        a_r = 1'b1; a_addr = 32'd1024;
        repeat (3) @(negedge clk);
        #1;
        check("reset ready_a", 32'(a_ready), 32'd1);
        check("reset ready_b", 32'(b_ready), 32'd1);
        reset = 1'b0;
        a_r   = 1'b0;
        #1;
        check("reset rdata", a_rdata, 32'd0);
        check("reset addr_err", 32'(a_err), 32'd0);
        check("reset stall_cnt", 32'(a_stall), 32'd0);
        check("idle ready", 32'(a_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            access(0, 4, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset during the second BUSY cycle of a write must abort it.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'd1024, 32'hAAAA5555);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort busy ready", 32'(a_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("abort ready_in_reset", 32'(a_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("abort idle ready", 32'(a_ready), 32'd1);
        check("abort stall_cnt", 32'(a_stall), 32'd0);
        check("abort rdata", a_rdata, 32'd0);
        check("abort addr_err", 32'(a_err), 32'd0);
        exp_stall[0] = 0;
        exp_stall[1] = 0;
        access(0, 4, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0, "abort readback");

        // Minimum-wait configuration.
        access(1, 1, 1'b0, 1'b1, 32'd1028, 32'h12345678, 32'h00000000, 1'b0, "w1 write");
        access(1, 1, 1'b1, 1'b0, 32'd1028, 32'd0, 32'h12345678, 1'b0, "w1 read");
        access(1, 1, 1'b1, 1'b0, 32'd1026, 32'd0, 32'h00000000, 1'b1, "w1 misaligned");

        // A held request is served once per IDLE/DONE pair.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'd1028, 32'd0);
        #1;
        check("b2b c0 ready", 32'(b_ready), 32'd0);
        @(negedge clk); #1;
        check("b2b c1 ready", 32'(b_ready), 32'd1);
        check("b2b c1 rdata", b_rdata, 32'h12345678);
        @(negedge clk); #1;
        check("b2b c2 ready", 32'(b_ready), 32'd0);
        @(negedge clk); #1;
        check("b2b c3 ready", 32'(b_ready), 32'd1);
        check("b2b stall_cnt", 32'(b_stall), 32'(exp_stall[1] + 2));
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Saturation: a faulting read held continuously on the long-wait instance.
        @(negedge clk);
        c_r = 1'b1;
        c_addr = 32'd0;
        repeat (256) @(negedge clk);
        check("sat partial", 32'(c_stall), 32'd255);
        n = 0;
        while (c_stall != 16'hFFFF && n < 70000) begin
            @(negedge clk);
            n++;
        end
        check("sat reached", 32'(c_stall), 32'h0000FFFF);
        repeat (600) @(negedge clk);
        check("sat held", 32'(c_stall), 32'h0000FFFF);
        c_r = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
